// File: rtl/azadi_pinmux_cfg.sv
// Pad multiplexer with per-pad configuration registers, input synchronizers and
// glitch filters, plus a single-cycle register port with a sticky lock.
module azadi_pinmux_cfg #(
    parameter int NUM_IO     = 24,
    parameter int NUM_PERIPH = 16,
    parameter int FILT_W     = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  reg_req_i,
    input  logic                  reg_we_i,
    input  logic [7:0]            reg_addr_i,
    input  logic [31:0]           reg_wdata_i,
    output logic [31:0]           reg_rdata_o,
    output logic                  reg_ack_o,
    output logic                  reg_err_o,
    input  logic [NUM_PERIPH-1:0] periph_out_i,
    input  logic [NUM_PERIPH-1:0] periph_oe_i,
    output logic [NUM_PERIPH-1:0] periph_in_o,
    input  logic [NUM_IO-1:0]     io_in_i,
    output logic [NUM_IO-1:0]     io_out_o,
    output logic [NUM_IO-1:0]     io_oeb_o,
    output logic [NUM_IO-1:0]     io_ren_o
);

    localparam int SEL_W  = $clog2(NUM_PERIPH + 1);
    localparam int IO_W   = $clog2(NUM_IO);
    localparam int PIDX_W = (NUM_PERIPH > 1) ? $clog2(NUM_PERIPH) : 1;
    localparam logic [7:0] ADDR_LOCK = 8'(NUM_IO);
    localparam logic [7:0] ADDR_FTHR = 8'(NUM_IO + 1);

    typedef struct packed {
        logic             filt;
        logic             pull;
        logic             inv;
        logic [SEL_W-1:0] sel;
    } padcfg_t;

    padcfg_t           cfg_q [NUM_IO];
    padcfg_t           cfg_d [NUM_IO];
    logic [FILT_W-1:0] cnt_q [NUM_IO];
    logic [FILT_W-1:0] cnt_d [NUM_IO];
    logic [FILT_W-1:0] fthr_q, fthr_d;
    logic              lock_q, lock_d;
    logic [NUM_IO-1:0] sync1_q, sync2_q, sync_val, filt_q, filt_d, cfg_chg;
    logic              ack_q, err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              addr_pad, addr_ok, wsel_bad;
    logic [IO_W-1:0]   pad_idx;
    logic [SEL_W-1:0]  wsel;
    padcfg_t           wr_cfg;
    logic              unused_wdata;

    // SEL is 1-based; SEL=k routes peripheral function k-1.
    function automatic logic [PIDX_W-1:0] sel2idx(input logic [SEL_W-1:0] sel);
        return PIDX_W'(sel - SEL_W'(1));
    endfunction

    assign addr_pad     = reg_addr_i < ADDR_LOCK;
    assign addr_ok      = reg_addr_i <= ADDR_FTHR;
    assign pad_idx      = reg_addr_i[IO_W-1:0];
    assign wsel         = reg_wdata_i[SEL_W-1:0];
    assign wsel_bad     = wsel > SEL_W'(NUM_PERIPH);
    assign wr_cfg       = '{filt: reg_wdata_i[10], pull: reg_wdata_i[9],
                            inv: reg_wdata_i[8], sel: wsel_bad ? '0 : wsel};
    assign unused_wdata = ^reg_wdata_i[31:11];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        cfg_d   = cfg_q;
        lock_d  = lock_q;
        fthr_d  = fthr_q;
        cfg_chg = '0;
        err_d   = 1'b0;
        rdata_d = '0;
        if (reg_req_i) begin
            if (!addr_ok) begin
                err_d = 1'b1;
            end else if (reg_we_i) begin
                if (lock_q) begin
                    err_d = 1'b1;
                end else if (addr_pad) begin
                    cfg_d[pad_idx]   = wr_cfg;
                    err_d            = wsel_bad;
                    cfg_chg[pad_idx] = (wr_cfg.sel != cfg_q[pad_idx].sel) ||
                                       (wr_cfg.filt != cfg_q[pad_idx].filt);
                end else if (reg_addr_i == ADDR_LOCK) begin
                    lock_d = lock_q | reg_wdata_i[0];
                end else begin
                    fthr_d = reg_wdata_i[FILT_W-1:0];
                end
            end else if (addr_pad) begin
                rdata_d[SEL_W-1:0] = cfg_q[pad_idx].sel;
                rdata_d[8]         = cfg_q[pad_idx].inv;
                rdata_d[9]         = cfg_q[pad_idx].pull;
                rdata_d[10]        = cfg_q[pad_idx].filt;
            end else if (reg_addr_i == ADDR_LOCK) begin
                rdata_d[0] = lock_q;
            end else begin
                rdata_d[FILT_W-1:0] = fthr_q;
            end
        end
    end

    // The filter steps with the old configuration; a SEL/FILT change then wipes the count.
    always_comb begin
        for (int n = 0; n < NUM_IO; n++) begin
            sync_val[n] = sync2_q[n] ^ cfg_q[n].inv;
            filt_d[n]   = filt_q[n];
            cnt_d[n]    = cnt_q[n];
            if (!cfg_q[n].filt) begin
                filt_d[n] = sync_val[n];
                cnt_d[n]  = '0;
            end else if (sync_val[n] == filt_q[n]) begin
                cnt_d[n] = '0;
            end else if (cnt_q[n] >= fthr_q) begin
                filt_d[n] = sync_val[n];
                cnt_d[n]  = '0;
            end else begin
                cnt_d[n] = cnt_q[n] + FILT_W'(1);
            end
            if (cfg_chg[n]) begin
                cnt_d[n] = '0;
            end
        end
    end

    // Walking downward lets the lowest-index pad win the periph_in_o slot.
    always_comb begin
        io_out_o    = '0;
        io_oeb_o    = '1;
        io_ren_o    = '1;
        periph_in_o = '0;
        for (int n = NUM_IO - 1; n >= 0; n--) begin
            io_ren_o[n] = ~cfg_q[n].pull;
            if (cfg_q[n].sel != '0) begin
                io_out_o[n]                      = periph_out_i[sel2idx(cfg_q[n].sel)] ^ cfg_q[n].inv;
                io_oeb_o[n]                      = ~periph_oe_i[sel2idx(cfg_q[n].sel)];
                periph_in_o[sel2idx(cfg_q[n].sel)] = filt_q[n];
            end
        end
    end

    // NOTE: state updates use <= so every flop samples the pre-edge value of every other.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the config array is reset too, because it drives the pads straight out of reset.
            for (int n = 0; n < NUM_IO; n++) begin
                cfg_q[n] <= '0;
                cnt_q[n] <= '0;
            end
            fthr_q  <= '0;
            lock_q  <= 1'b0;
            sync1_q <= '0;
            sync2_q <= '0;
            filt_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            for (int n = 0; n < NUM_IO; n++) begin
                cfg_q[n] <= cfg_d[n];
                cnt_q[n] <= cnt_d[n];
            end
            fthr_q  <= fthr_d;
            lock_q  <= lock_d;
            sync1_q <= io_in_i;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            ack_q   <= reg_req_i;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign reg_ack_o   = ack_q;
    assign reg_err_o   = err_q;
    assign reg_rdata_o = rdata_q;

endmodule

// File: tb/tb_azadi_pinmux_cfg.sv
// Bench for azadi_pinmux_cfg: directed scenarios plus a randomized run, all outputs
// compared every cycle against a behavioural model of the register and pad rules.
module tb_azadi_pinmux_cfg;

    localparam int NUM_IO     = 24;
    localparam int NUM_PERIPH = 16;
    localparam int FILT_W     = 8;
    localparam int SEL_W      = $clog2(NUM_PERIPH + 1);
    localparam int A_LOCK     = NUM_IO;
    localparam int A_FTHR     = NUM_IO + 1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  reg_req = 1'b0;
    logic                  reg_we = 1'b0;
    logic [7:0]            reg_addr = '0;
    logic [31:0]           reg_wdata = '0;
    logic [31:0]           reg_rdata;
    logic                  reg_ack, reg_err;
    logic [NUM_PERIPH-1:0] periph_out = '0, periph_oe = '0, periph_in;
    logic [NUM_IO-1:0]     io_in = '0, io_out, io_oeb, io_ren;

    azadi_pinmux_cfg #(.NUM_IO(NUM_IO), .NUM_PERIPH(NUM_PERIPH), .FILT_W(FILT_W)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .reg_req_i(reg_req), .reg_we_i(reg_we), .reg_addr_i(reg_addr), .reg_wdata_i(reg_wdata),
        .reg_rdata_o(reg_rdata), .reg_ack_o(reg_ack), .reg_err_o(reg_err),
        .periph_out_i(periph_out), .periph_oe_i(periph_oe), .periph_in_o(periph_in),
        .io_in_i(io_in), .io_out_o(io_out), .io_oeb_o(io_oeb), .io_ren_o(io_ren)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: configuration as plain integers, inputs seen two edges late,
    // filtered value flips after more than FTHR consecutive disagreeing samples.
    int                m_sel [NUM_IO];
    bit                m_inv [NUM_IO];
    bit                m_pull[NUM_IO];
    bit                m_fen [NUM_IO];
    bit                m_filt[NUM_IO];
    int                streak[NUM_IO];
    bit                m_lock = 1'b0;
    int                m_fthr = 0;
    logic [NUM_IO-1:0] hist[$];
    logic [NUM_IO-1:0] seen;
    bit                e_ack = 1'b0, e_err = 1'b0, sv;
    logic [31:0]       e_rdata = '0;
    int                a, ws;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NUM_IO; n++) begin
                m_sel[n] = 0; m_inv[n] = 0; m_pull[n] = 0; m_fen[n] = 0;
                m_filt[n] = 0; streak[n] = 0;
            end
            m_lock = 0; m_fthr = 0;
            hist.delete();
            hist.push_back({NUM_IO{1'b0}});
            hist.push_back({NUM_IO{1'b0}});
            e_ack = 0; e_err = 0; e_rdata = '0;
        end else begin
            seen = hist[1];
            hist.push_front(io_in);
            void'(hist.pop_back());
            for (int n = 0; n < NUM_IO; n++) begin
                sv = seen[n] ^ m_inv[n];
                if (!m_fen[n]) begin
                    m_filt[n] = sv; streak[n] = 0;
                end else if (sv == m_filt[n]) begin
                    streak[n] = 0;
                end else begin
                    streak[n]++;
                    if (streak[n] > m_fthr) begin
                        m_filt[n] = sv; streak[n] = 0;
                    end
                end
            end
            e_ack = reg_req; e_err = 0; e_rdata = '0;
            if (reg_req) begin
                a = int'(reg_addr);
                if (a > A_FTHR) begin
                    e_err = 1;
                end else if (reg_we) begin
                    if (m_lock) begin
                        e_err = 1;
                    end else if (a < NUM_IO) begin
                        ws = int'(reg_wdata[SEL_W-1:0]);
                        if (ws > NUM_PERIPH) begin
                            e_err = 1; ws = 0;
                        end
                        if (ws != m_sel[a] || reg_wdata[10] != m_fen[a]) streak[a] = 0;
                        m_sel[a] = ws; m_inv[a] = reg_wdata[8];
                        m_pull[a] = reg_wdata[9]; m_fen[a] = reg_wdata[10];
                    end else if (a == A_LOCK) begin
                        m_lock = m_lock | reg_wdata[0];
                    end else begin
                        m_fthr = int'(reg_wdata[FILT_W-1:0]);
                    end
                end else if (a < NUM_IO) begin
                    e_rdata = m_sel[a] + (m_inv[a] ? 32'h100 : 0) + (m_pull[a] ? 32'h200 : 0)
                            + (m_fen[a] ? 32'h400 : 0);
                end else if (a == A_LOCK) begin
                    e_rdata = m_lock ? 32'd1 : 32'd0;
                end else begin
                    e_rdata = m_fthr;
                end
            end
        end
    end

    logic [NUM_IO-1:0]     e_out, e_oeb, e_ren;
    logic [NUM_PERIPH-1:0] e_pin;

    always @(negedge clk) begin
        for (int n = 0; n < NUM_IO; n++) begin
            e_ren[n] = ~m_pull[n];
            if (m_sel[n] == 0) begin
                e_out[n] = 1'b0; e_oeb[n] = 1'b1;
            end else begin
                e_out[n] = periph_out[m_sel[n] - 1] ^ m_inv[n];
                e_oeb[n] = ~periph_oe[m_sel[n] - 1];
            end
        end
        e_pin = '0;
        for (int k = 1; k <= NUM_PERIPH; k++) begin
            for (int n = 0; n < NUM_IO; n++) begin
                if (m_sel[n] == k) begin
                    e_pin[k-1] = m_filt[n];
                    break;
                end
            end
        end
        check("mon_io_out", io_out, e_out);
        check("mon_io_oeb", io_oeb, e_oeb);
        check("mon_io_ren", io_ren, e_ren);
        check("mon_periph_in", periph_in, e_pin);
        check("mon_ack", reg_ack, e_ack);
        check("mon_err", reg_err, e_err);
        check("mon_rdata", reg_rdata, e_rdata);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_xfer(input logic we, input int addr, input logic [31:0] wd,
                            output logic err, output logic [31:0] rd);
        reg_req = 1'b1; reg_we = we; reg_addr = 8'(addr); reg_wdata = wd;
        tick();
        check("ack_after_req", reg_ack, 1'b1);
        err = reg_err; rd = reg_rdata;
        reg_req = 1'b0; reg_we = 1'b0;
    endtask

    logic        err;
    logic [31:0] rd, wd;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_oeb", io_oeb, {NUM_IO{1'b1}});
        check("rst_out", io_out, '0);
        check("rst_ren", io_ren, {NUM_IO{1'b1}});
        check("rst_pin", periph_in, '0);
        rst_n = 1'b1;
        tick();

        // Read after reset, ack pulse width
        reg_xfer(0, 0, '0, err, rd);
        check("rd0_data", rd, 0);
        check("rd0_err", err, 0);
        tick();
        check("ack_one_cycle", reg_ack, 0);
        check("oeb_idle", io_oeb, {NUM_IO{1'b1}});

        // Output path with inversion
        reg_xfer(1, 3, 32'h105, err, rd);
        check("wr3_err", err, 0);
        periph_out[4] = 1'b1; periph_oe[4] = 1'b1;
        #1;
        check("pad3_out_inv", io_out[3], 0);
        check("pad3_oeb", io_oeb[3], 0);
        periph_out[4] = 1'b0;
        #1;
        check("pad3_out_inv0", io_out[3], 1);
        reg_xfer(0, 3, '0, err, rd);
        check("pad3_rb", rd, 32'h105);

        // Two pads on one function: lowest index wins, 3-cycle latency
        reg_xfer(1, 2, 32'h2, err, rd);
        reg_xfer(1, 7, 32'h2, err, rd);
        io_in[2] = 1'b1; io_in[7] = 1'b0;
        tick(); tick();
        check("sync_lat2", periph_in[1], 0);
        tick();
        check("sync_lat3", periph_in[1], 1);
        io_in[2] = 1'b0; io_in[7] = 1'b1;
        repeat (3) tick();
        check("lowest_wins", periph_in[1], 0);

        // Glitch filter, FTHR=4
        reg_xfer(1, A_FTHR, 32'd4, err, rd);
        reg_xfer(1, 0, 32'h401, err, rd);
        repeat (5) tick();
        io_in[0] = 1'b1;
        repeat (3) tick();
        io_in[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("filt_short_pulse", periph_in[0], 0);
        end
        io_in[0] = 1'b1;
        repeat (6) tick();
        check("filt_pre_rise", periph_in[0], 0);
        tick();
        check("filt_rise7", periph_in[0], 1);
        repeat (3) tick();
        io_in[0] = 1'b0;
        repeat (6) tick();
        check("filt_pre_fall", periph_in[0], 1);
        tick();
        check("filt_fall7", periph_in[0], 0);

        // Lock
        reg_xfer(1, A_LOCK, 32'h1, err, rd);
        check("lock_wr_err", err, 0);
        reg_xfer(1, 0, 32'h3, err, rd);
        check("locked_wr_err", err, 1);
        reg_xfer(0, 0, '0, err, rd);
        check("locked_keep", rd, 32'h401);
        check("locked_rd_err", err, 0);
        reg_xfer(1, A_FTHR, 32'd9, err, rd);
        check("locked_fthr_err", err, 1);
        reg_xfer(0, A_FTHR, '0, err, rd);
        check("locked_fthr_keep", rd, 4);
        reg_xfer(1, A_LOCK, 32'h0, err, rd);
        check("locked_lock_err", err, 1);

        // Reset in the middle of an access aborts it and clears LOCK
        reg_req = 1'b1; reg_we = 1'b1; reg_addr = 8'd1; reg_wdata = 32'h7;
        #2 rst_n = 1'b0;
        tick();
        check("abort_ack", reg_ack, 0);
        reg_req = 1'b0; reg_we = 1'b0;
        rst_n = 1'b1;
        tick();
        check("abort_ack2", reg_ack, 0);
        reg_xfer(0, A_LOCK, '0, err, rd);
        check("lock_cleared", rd, 0);
        reg_xfer(0, 1, '0, err, rd);
        check("abort_no_write", rd, 0);
        reg_xfer(1, 0, 32'h1, err, rd);
        check("unlocked_wr_err", err, 0);

        // SEL overflow and bad addresses
        reg_xfer(1, 5, 32'h311, err, rd);
        check("sel_ovf_err", err, 1);
        reg_xfer(0, 5, '0, err, rd);
        check("sel_ovf_rb", rd, 32'h300);
        check("sel_ovf_ren", io_ren[5], 0);
        reg_xfer(1, 6, 32'h10, err, rd);
        check("sel_max_err", err, 0);
        reg_xfer(0, 200, '0, err, rd);
        check("bad_addr_err", err, 1);
        check("bad_addr_data", rd, 0);
        reg_xfer(1, A_FTHR + 1, 32'hFF, err, rd);
        check("addr26_err", err, 1);
        reg_xfer(0, A_FTHR, '0, err, rd);
        check("fthr_rd_err", err, 0);
        check("fthr_unchanged", rd, 0);

        // Randomized traffic, checked every cycle by the monitor
        for (int i = 0; i < 3000; i++) begin
            periph_out = NUM_PERIPH'($urandom);
            periph_oe  = NUM_PERIPH'($urandom);
            io_in      = io_in ^ NUM_IO'($urandom & $urandom & $urandom);
            if (!reg_req && $urandom_range(0, 2) == 0) begin
                int r;
                r = $urandom_range(0, 19);
                if (r < 16)       a = $urandom_range(0, NUM_IO - 1);
                else if (r < 18)  a = A_FTHR;
                else if (r == 18) a = A_LOCK;
                else              a = $urandom_range(NUM_IO + 2, 255);
                wd = $urandom;
                wd[SEL_W-1:0] = SEL_W'($urandom_range(0, NUM_PERIPH + 2));
                if (a == A_FTHR) wd[7:0] = 8'($urandom_range(0, 5));
                if (a == A_LOCK) wd[0] = 1'b0;
                reg_req = 1'b1; reg_we = 1'($urandom_range(0, 1));
                reg_addr = 8'(a); reg_wdata = wd;
            end else begin
                reg_req = 1'b0; reg_we = 1'b0;
            end
            tick();
        end
        reg_req = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/azadi_pinmux_cfg.md
AZADI_PINMUX_CFG -- requirements
Module: azadi_pinmux_cfg

Interface
REQ-001 Parameters SHALL be, one per line:
- NUM_IO, 24, number of muxed pads.
- NUM_PERIPH, 16, number of peripheral pin-functions.
- FILT_W, 8, glitch-filter counter width.
- SEL_W, $clog2(NUM_PERIPH+1), derived pad-select width (localparam).
REQ-002 The block SHALL have one clock, clk_i; the reset SHALL be asynchronous and active-low, rst_ni.
REQ-003 Ports SHALL be, one per line:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- reg_req_i  in  1  register access request, single-cycle pulse.
- reg_we_i  in  1  1 = write, 0 = read.
- reg_addr_i  in  8  word address.
- reg_wdata_i  in  32  write data.
- reg_rdata_o  out  32  read data, valid with reg_ack_o.
- reg_ack_o  out  1  access complete.
- reg_err_o  out  1  access error, valid with reg_ack_o.
- periph_out_i  in  NUM_PERIPH  peripheral output values.
- periph_oe_i  in  NUM_PERIPH  peripheral output enables, active high.
- periph_in_o  out  NUM_PERIPH  peripheral input values.
- io_in_i  in  NUM_IO  pad input values.
- io_out_o  out  NUM_IO  pad output values.
- io_oeb_o  out  NUM_IO  pad output enables, active low.
- io_ren_o  out  NUM_IO  pad pull enables, active low.

Function
REQ-004 Register map (word addresses):
- 0..NUM_IO-1: PADCFG[n], with fields [SEL_W-1:0] SEL, [8] INV, [9] PULL, [10] FILT; other bits read 0.
- NUM_IO: LOCK, bit [0], sticky.
- NUM_IO+1: FTHR, bits [FILT_W-1:0].
REQ-005 Register access:
- reg_ack_o SHALL pulse exactly one cycle after reg_req_i.
- reg_rdata_o and reg_err_o SHALL be registered and qualified by reg_ack_o; reg_rdata_o SHALL be 0 whenever reg_ack_o is 0.
REQ-006 An access to an address above NUM_IO+1 SHALL ack with reg_err_o=1, read data 0, and no state change.
REQ-007 Writes with SEL > NUM_PERIPH SHALL store SEL=0 and ack with reg_err_o=1; the INV, PULL and FILT fields of that write SHALL still be stored.
REQ-008 Once LOCK=1:
- writes to PADCFG, FTHR and LOCK SHALL ack with reg_err_o=1 and change nothing.
- reads SHALL be unaffected.
- only reset SHALL clear LOCK.
REQ-009 Output path, purely combinational from configuration and peripheral signals, for SEL=k>0:
- io_out_o[n] = periph_out_i[k-1] XOR INV.
- io_oeb_o[n] = ~periph_oe_i[k-1].
REQ-010 For SEL=0 the pad SHALL be tri-stated: io_out_o[n]=0, io_oeb_o[n]=1.
REQ-011 io_ren_o[n] SHALL equal ~PULL[n].
REQ-012 Each io_in_i[n] SHALL pass through a 2-flop synchronizer, then XOR INV[n].
REQ-013 Glitch filter with FILT=1:
- a per-pad FILT_W counter SHALL count consecutive cycles in which the synchronized value differs from the filtered value.
- the filtered value SHALL update when the count reaches FTHR, and the counter SHALL then clear.
- any cycle in which the values match SHALL clear the counter.
- FTHR=0 SHALL give unfiltered timing.
REQ-014 With FILT=0 the filtered value SHALL follow the synchronized value each cycle; the counter SHALL be held at 0.
REQ-015 Input latency, io_in_i to periph_in_o:
- 3 cycles with FILT=0 or FTHR=0.
- 3+FTHR cycles for a stable input with FILT=1.
REQ-016 periph_in_o[k-1] SHALL take the filtered value of the lowest-index pad with SEL=k, or 0 if no pad selects k.
REQ-017 Changing SEL or FILT SHALL take effect on the cycle after the write ack; in-flight filter counts for that pad SHALL clear.
REQ-018 Simultaneous register write and filter update on the same cycle SHALL resolve as follows: the filter completes its update, then the new configuration applies.

Reset
REQ-019 On rst_ni=0, asynchronously, the following SHALL be 0: all PADCFG, LOCK, synchronizer flops, filtered values, filter counters, reg_ack_o, reg_err_o and reg_rdata_o.
REQ-020 FTHR SHALL reset to 0.
REQ-021 Resulting outputs during and after reset: io_oeb_o all 1, io_out_o all 0, io_ren_o all 1, periph_in_o all 0.
REQ-022 Reset asserted during an access SHALL abort it; no ack SHALL follow release.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Reset then read PADCFG[0] -> ack 1 cycle later, rdata=0, err=0; io_oeb_o all 1.
- Write PADCFG[3]=SEL 5, INV 1; drive periph_out_i[4]=1, periph_oe_i[4]=1 -> io_out_o[3]=0, io_oeb_o[3]=0.
- PADCFG[2] and PADCFG[7] both SEL=2; drive io_in_i[2]=1, io_in_i[7]=0 -> periph_in_o[1]=1 after 3 cycles.
- FTHR=4, FILT=1 on pad 0; 3-cycle pulse on io_in_i[0] -> no change at periph_in; 10-cycle pulse -> rises 7 cycles after the edge.
- Write LOCK=1, then write PADCFG[0] -> err=1, value unchanged; reset clears LOCK.
- Write SEL=NUM_PERIPH+1 -> err=1, readback SEL=0; address 200 -> err=1, rdata=0.
